mem_port: RTL and testbench

Memory access sequencer directly downstream of the address-arithmetic unit. It captures the 16-bit address that unit drives on the shared address bus into a memory address register (MAR). It then runs a byte or little-endian 16-bit (two-byte) access to external 8-bit memory over a req/ack handshake. It returns the assembled data word to the register side via a tri-stated data bus output.

---
 rtl/mem_port_pkg.sv | 29 ++
 rtl/mem_port.sv | 196 +++++++++++++++++++
 tb/tb_mem_port.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared CPU types: register-port opcodes, memory-ALU opcodes and the
// mem_port sequencer state encoding.
package mem_port_pkg;

  // Register-side bus control: READ samples a bus, WRITE drives one.
  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2,
    REG_OP_HOLD  = 2'd3
  } reg_op_t;

  // Operations of the address-arithmetic unit feeding the address bus.
  typedef enum logic [1:0] {
    MEMALU_OP_PASS = 2'd0,
    MEMALU_OP_INC  = 2'd1,
    MEMALU_OP_DEC  = 2'd2,
    MEMALU_OP_ADD  = 2'd3
  } memalu_op_t;

  // Memory access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_LO = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_DONE   = 2'd3
  } mem_port_state_t;

endpackage

// File: rtl/mem_port.sv
// Memory access sequencer: captures the address bus into MAR, runs a byte or
// little-endian two-byte access over a req/ack handshake to 8-bit memory and
// presents the assembled word on a tri-stated register-side bus.
// Optional feature: define MEM_PORT_TIMEOUT_EN to abort a byte that waits
// WAIT_LIMIT cycles without ack (sets the sticky err flag).
module mem_port
  import mem_port_pkg::*;
#(
  parameter int HALF_WIDTH = 8,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*HALF_WIDTH-1:0] addr_in,
  input  reg_op_t                 addr_ctl,
  input  logic                    start,
  input  logic                    wide,
  input  logic                    we,
  input  logic [2*HALF_WIDTH-1:0] wdata,
  input  reg_op_t                 data_ctl,
  output logic [2*HALF_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [2*HALF_WIDTH-1:0] mem_addr,
  output logic [HALF_WIDTH-1:0]   mem_wdata,
  input  logic [HALF_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int W = 2 * HALF_WIDTH;

  mem_port_state_t state_reg, state_next;

  logic [W-1:0]          mar_reg;
  logic [W-1:0]          rbuf_reg;
  logic [W-1:0]          data_reg;
  logic [W-1:0]          wdata_reg;
  logic                  wide_reg;
  logic                  we_reg;
  logic [W-1:0]          mem_addr_reg;
  logic [HALF_WIDTH-1:0] mem_wdata_reg;

  logic accept_start;
  logic mar_load;
  logic in_req;
  logic timeout_hit;
  logic access_err;

  assign in_req   = (state_reg == ST_REQ_LO) || (state_reg == ST_REQ_HI);
  assign mar_load = (state_reg == ST_IDLE) && (addr_ctl == REG_OP_READ);

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  logic [WAIT_W-1:0] wait_reg;
  logic              err_reg;

  // Last allowed wait cycle of the current byte has passed without ack.
  assign timeout_hit = in_req && !mem_ack && (wait_reg == WAIT_W'(WAIT_LIMIT - 1));

  // Per-byte wait counter; restarts whenever a request state is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_reg <= '0;
    end else if (in_req && (state_next == state_reg)) begin
      wait_reg <= wait_reg + WAIT_W'(1);
    end else begin
      wait_reg <= '0;
    end
  end

  // Sticky timeout flag, cleared only when a new access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (accept_start) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign access_err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign access_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one request phase per byte, then a single DONE cycle.
  always_comb begin
    state_next   = state_reg;
    accept_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (mem_ack) begin
          state_next = wide_reg ? ST_REQ_HI : ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_REQ_HI: begin
        if (mem_ack || timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // MAR only follows the address bus while idle; the access never alters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_reg <= '0;
    end else if (mar_load) begin
      mar_reg <= addr_in;
    end
  end

  // Latch the access parameters on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_reg  <= 1'b0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else if (accept_start) begin
      wide_reg  <= wide;
      we_reg    <= we;
      wdata_reg <= wdata;
    end
  end

  // Memory-side address/write byte: loaded at start (a coincident MAR load
  // wins), advanced to the high byte on the edge that takes the low-byte ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (accept_start) begin
      mem_addr_reg  <= mar_load ? addr_in : mar_reg;
      mem_wdata_reg <= wdata[HALF_WIDTH-1:0];
    end else if ((state_reg == ST_REQ_LO) && mem_ack && wide_reg) begin
      mem_addr_reg  <= mar_reg + W'(1);
      mem_wdata_reg <= wdata_reg[W-1:HALF_WIDTH];
    end
  end

  // Collect the read bytes as they are acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_reg <= '0;
    end else if (mem_ack && (state_reg == ST_REQ_LO)) begin
      rbuf_reg[HALF_WIDTH-1:0] <= mem_rdata;
    end else if (mem_ack && (state_reg == ST_REQ_HI)) begin
      rbuf_reg[W-1:HALF_WIDTH] <= mem_rdata;
    end
  end

  // Commit read data in DONE; writes and aborted accesses leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if ((state_reg == ST_DONE) && !we_reg && !access_err) begin
      data_reg <= wide_reg ? rbuf_reg : {{HALF_WIDTH{1'b0}}, rbuf_reg[HALF_WIDTH-1:0]};
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err       = access_err;
  assign mem_req   = in_req;
  assign mem_we    = in_req && we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign data_out  = (data_ctl == REG_OP_WRITE) ? data_reg : {W{1'bz}};

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: a byte-wide memory responder with
// configurable wait states, directed scenarios and randomized accesses
// checked against a transaction-level model (MAR, data register, byte log).
module tb_mem_port;
  import mem_port_pkg::*;

  localparam int H = 8;
  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  addr_in;
  reg_op_t       addr_ctl;
  logic          start;
  logic          wide;
  logic          we;
  logic [W-1:0]  wdata;
  reg_op_t       data_ctl;
  wire  [W-1:0]  data_out;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [H-1:0]  mem_wdata;
  logic [H-1:0]  mem_rdata;
  logic          mem_ack;

  mem_port #(.HALF_WIDTH(H), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .addr_ctl(addr_ctl),
    .start(start), .wide(wide), .we(we), .wdata(wdata), .data_ctl(data_ctl),
    .data_out(data_out), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image and log of every acknowledged byte transfer.
  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [H-1:0] wdata;
  } xfer_t;

  logic [H-1:0] mem [0:65535];
  xfer_t        log_q [$];
  int           waits     = 0;
  bit           never_ack = 0;
  int           wait_cnt  = 0;

  // Responder: ack each byte after 'waits' wait cycles, garbage data otherwise.
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !never_ack) begin
      if (wait_cnt >= waits) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        log_q.push_back('{mem_addr, mem_we, mem_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
        wait_cnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  // Reference model state.
  logic [W-1:0] m_mar  = '0;
  logic [W-1:0] m_data = '0;

  // Runs one access starting at the current negedge and checks it end to end.
  task automatic access(input logic [W-1:0] addr, input bit load, input bit wd,
                        input bit wr, input logic [W-1:0] wv, input int nw,
                        input bit interfere);
    logic [W-1:0] a0, a1, exp_rd;
    int exp_done, cyc, nx;
    xfer_t x;
    waits = nw;
    if (load) m_mar = addr;
    a0 = m_mar;
    a1 = a0 + 16'd1;
    exp_rd   = wd ? {mem[a1], mem[a0]} : {8'h00, mem[a0]};
    exp_done = wd ? (3 + 2 * nw) : (2 + nw);
    nx       = wd ? 2 : 1;
    addr_in  = addr;
    addr_ctl = load ? REG_OP_READ : REG_OP_NONE;
    start = 1'b1; wide = wd; we = wr; wdata = wv;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0; addr_ctl = REG_OP_NONE;
      addr_in = 16'($urandom); wide = 1'($urandom); we = 1'($urandom); wdata = 16'($urandom);
      if (interfere && cyc == 1) begin
        start = 1'b1; addr_ctl = REG_OP_READ; addr_in = 16'h5555;
      end
      if (cyc == 1) begin
        check("req_c1", 16'(mem_req), 16'd1);
        check("busy_c1", 16'(busy), 16'd1);
        check("err_c1", 16'(err), 16'd0);
      end
      if (done === 1'b1) break;
    end
    check("done_cycle", 16'(cyc), 16'(exp_done));
    check("err_done", 16'(err), 16'd0);
    check("nxfer", 16'(log_q.size()), 16'(nx));
    for (int i = 0; i < nx; i++) begin
      if (log_q.size() > 0) begin
        x = log_q.pop_front();
        check(i == 0 ? "addr_lo" : "addr_hi", x.addr, i == 0 ? a0 : a1);
        check("mem_we", 16'(x.we), 16'(wr));
        if (wr) check("wbyte", 16'(x.wdata), 16'(i == 0 ? wv[7:0] : wv[15:8]));
      end
    end
    log_q.delete();
    if (!wr) m_data = exp_rd;
    @(negedge clk);
    check("done_pulse", 16'(done), 16'd0);
    data_ctl = REG_OP_WRITE;
    #1 check("data_out", data_out, m_data);
    data_ctl = REG_OP_NONE;
    #1 check("data_z", data_out, 16'hzzzz);
    $display("access addr=%h load=%0d wide=%0d we=%0d wdata=%h waits=%0d done@%0d data=%h",
             a0, load, wd, wr, wv, nw, cyc, m_data);
  endtask

`ifdef MEM_PORT_TIMEOUT_EN
  // Byte read that is never acknowledged: must abort with err after 15 cycles.
  task automatic timeout_access(input logic [W-1:0] addr);
    int cyc;
    never_ack = 1;
    m_mar = addr;
    addr_in = addr; addr_ctl = REG_OP_READ; start = 1'b1; wide = 1'b0; we = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0; addr_ctl = REG_OP_NONE;
      if (done === 1'b1) break;
    end
    check("to_done_cycle", 16'(cyc), 16'd16);
    check("to_err", 16'(err), 16'd1);
    check("to_nxfer", 16'(log_q.size()), 16'd0);
    never_ack = 0;
    @(negedge clk);
    check("to_err_sticky", 16'(err), 16'd1);
    data_ctl = REG_OP_WRITE;
    #1 check("to_data", data_out, m_data);
    data_ctl = REG_OP_NONE;
    #1;
    $display("timeout addr=%h done@%0d err=%0d", addr, cyc, err);
  endtask
`endif

  initial begin
    rst_n = 1'b0; addr_in = '0; addr_ctl = REG_OP_NONE; start = 1'b0;
    wide = 1'b0; we = 1'b0; wdata = '0; data_ctl = REG_OP_NONE;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_req", 16'(mem_req), 16'd0);
    check("rst_we", 16'(mem_we), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_addr", mem_addr, 16'd0);
    check("rst_wdata", 16'(mem_wdata), 16'd0);
    data_ctl = REG_OP_WRITE;
    #1 check("rst_data", data_out, 16'd0);
    data_ctl = REG_OP_NONE;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    mem[16'h1234] = 8'hAB;
    access(16'h1234, 1, 0, 0, 16'h0000, 0, 0);
    check("byte_read_val", m_data, 16'h00AB);
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    access(16'hFFFF, 1, 1, 0, 16'h0000, 0, 0);
    check("wrap_read_val", m_data, 16'h2211);
    access(16'h2000, 1, 1, 1, 16'hBEEF, 2, 0);
    check("wr_lo_mem", 16'(mem[16'h2000]), 16'h00EF);
    check("wr_hi_mem", 16'(mem[16'h2001]), 16'h00BE);
    access(16'h3000, 1, 1, 0, 16'h0000, 2, 1);
    access(16'h9999, 0, 0, 0, 16'h0000, 0, 0);

    // Load MAR without starting, then use it.
    addr_in = 16'h0F0F; addr_ctl = REG_OP_READ;
    @(negedge clk);
    addr_ctl = REG_OP_NONE;
    m_mar = 16'h0F0F;
    access(16'h7777, 0, 1, 0, 16'h0000, 1, 0);

    // Asynchronous reset in the high-byte phase.
    waits = 3;
    addr_in = 16'h4321; addr_ctl = REG_OP_READ; start = 1'b1; wide = 1'b1; we = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0; addr_ctl = REG_OP_NONE;
    end
    check("pre_rst_addr_hi", mem_addr, 16'h4322);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 16'(mem_req), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_done", 16'(done), 16'd0);
    check("mid_rst_we", 16'(mem_we), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    m_mar = '0;
    m_data = '0;
    $display("reset applied during high-byte request");
    @(negedge clk);
    access(16'hAAAA, 0, 0, 0, 16'h0000, 0, 0);

`ifdef MEM_PORT_TIMEOUT_EN
    timeout_access(16'h0BAD);
    access(16'h0BAD, 0, 1, 0, 16'h0000, 1, 0);
`endif

    // Randomized accesses.
    for (int n = 0; n < 30; n++) begin
      access(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
